// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM arbiter between instruction fetch and data load/store ports
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state;
  logic        own_if;
  logic [2:0]  cnt, len, mlen;
  logic [1:0]  idx;
  logic [31:0] rbuf, wbuf, nbuf;
  // Decode load/store length and merge the byte arriving from RAM into the read buffer
  always_comb begin
    mlen = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    idx = cnt[1:0] - 2'd1;
    nbuf = rbuf;
    nbuf[{idx, 3'b000} +: 8] = ram_din;
  end
  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own_if    <= 1'b0;
      cnt       <= 3'd0;
      len       <= 3'd0;
      rbuf      <= 32'd0;
      wbuf      <= 32'd0;
      if_done   <= 1'b0;
      if_data   <= 32'd0;
      mem_done  <= 1'b0;
      mem_rdata <= 32'd0;
      ram_addr  <= 32'd0;
      ram_wr    <= 1'b0;
      ram_dout  <= 8'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            own_if   <= 1'b0;
            len      <= mlen;
            cnt      <= 3'd0;
            rbuf     <= 32'd0;
            ram_addr <= mem_addr;
            busy     <= 1'b1;
            if (mem_we) begin
              state    <= WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              wbuf     <= mem_wdata >> 8;
            end else begin
              state <= READ;
            end
          end else if (if_req && !flush) begin
            own_if   <= 1'b1;
            len      <= 3'd4;
            cnt      <= 3'd0;
            rbuf     <= 32'd0;
            ram_addr <= if_addr;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (own_if && flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) rbuf <= nbuf;
            if (cnt + 3'd1 < len) ram_addr <= ram_addr + 32'd1;
            if (cnt == len) begin
              state <= DONE;
              if (own_if) begin
                if_done <= 1'b1;
                if_data <= nbuf;
              end else begin
                mem_done  <= 1'b1;
                mem_rdata <= nbuf;
              end
            end
          end
        end
        WRITE: begin
          if (cnt + 3'd1 < len) begin
            cnt      <= cnt + 3'd1;
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
          end else begin
            ram_wr   <= 1'b0;
            mem_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse, fetch complete
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 2/3 = 4 bytes
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse, load/store complete
- mem_rdata  out  32  load bytes, zero-filled above length (sign extension done by MEM)
- flush  in  1  branch/jump taken in EX, kills pending fetch
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after ram_addr
- busy  out  1  high in any state except IDLE

Function
REQ-002 FSM states SHALL be IDLE, READ, WRITE and DONE; all outputs SHALL be registered.
REQ-003 In IDLE, mem_req SHALL have priority over if_req; when both are high in the same cycle, the MEM request SHALL be granted.
REQ-004 In IDLE, if_req SHALL NOT be granted in any cycle where flush is high.
REQ-005 Grant SHALL latch base address, length N (fetch N=4), direction and write data; the byte counter SHALL be cleared to 0.
REQ-006 Grant SHALL move to READ for fetch/load and to WRITE for store.
REQ-007 READ: ram_addr SHALL equal base+i in cycle i+1 (i = 0..N-1), with ram_wr=0.
REQ-008 READ: ram_din SHALL be captured into byte i of the result at the end of cycle i+2.
REQ-009 READ: after byte N-1 is captured, the FSM SHALL go to DONE.
REQ-010 WRITE: ram_wr SHALL be 1, ram_addr SHALL be base+i and ram_dout SHALL be wdata[8i+7:8i] in cycle i+1 (i = 0..N-1); the FSM SHALL then go to DONE.
REQ-011 Latency, with cycle 0 the grant cycle: read done SHALL be high in cycle N+2 (fetch: cycle 6); write done SHALL be high in cycle N+1 (4-byte store: cycle 5).
REQ-012 DONE SHALL last exactly one cycle, pulse the owner's done, grant nothing and return to IDLE.
REQ-013 if_data/mem_rdata SHALL update only with their done pulse and SHALL hold until the next done pulse of the same port.
REQ-014 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 = 0x00000000); misaligned addresses SHALL be legal.
REQ-015 Flush while serving a fetch SHALL abort it: next state IDLE, no if_done, if_data unchanged, ram_wr stays 0.
REQ-016 Flush SHALL be ignored while serving a MEM load/store.
REQ-017 A request arriving while busy SHALL wait; it SHALL be sampled again in the first IDLE cycle.
REQ-018 ram_wr SHALL be 0 in every state other than WRITE.
REQ-019 A store of length N SHALL write exactly N bytes.

Reset
REQ-020 While rst=0, regardless of clock: state=IDLE; counter=0; if_done=mem_done=ram_wr=busy=0; ram_addr=0, ram_dout=0, if_data=0, mem_rdata=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it without a done pulse.
REQ-022 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-023 Fetch: if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> if_done in cycle 6, if_data=0x00000513, ram_addr 0x100..0x103 in cycles 1-4.
REQ-024 Simultaneous requests: if_req and mem_req (lw, addr 0x200) in the same cycle -> load served first; mem_done in cycle 6; fetch granted in the IDLE cycle after DONE.
REQ-025 Store: sh, addr 0xFFFFFFFF, wdata 0xAABBCCDD -> writes 0xDD@0xFFFFFFFF and 0xCC@0x00000000; exactly 2 ram_wr cycles; mem_done in cycle 3.
REQ-026 Flush: assert flush in cycle 3 of a fetch -> no if_done, if_data unchanged, FSM in IDLE in cycle 4; flush during a lb -> mem_done still in cycle 3.
REQ-027 Reset: drive rst=0 in cycle 2 of a 4-byte store -> ram_wr=0 immediately; no mem_done; after release, a new fetch completes normally.
